weight_preloader_param: RTL
===========================

Name: weight_preloader_param

Overview:
- Parametrised successor to the fixed 9-entry systolic-array weight preloader.
- Reads N_PE weights from a synchronous-read weight SRAM, starting at a programmable base address, with a programmable count.
- Latches each weight into a per-PE holding register and pulses that PE's preload enable.
- Adds a start/busy/done handshake, a memory-arbitration stall, and partial loads. Sits between the weight SRAM and the SA PE grid inside SA_Data_Loader.

Parameters:
- N_PE, 9, number of PEs/weights to load (array rows*cols).
- DATA_W, 8, weight width in bits.
- ADDR_W, 6, SRAM address width.
- CNT_W, $clog2(N_PE+1), width of the count input.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a load. Sampled only in IDLE.
- base_addr_i  in  ADDR_W  first SRAM address. Latched on accepted start.
- num_i  in  CNT_W  weights to load. 0 or >N_PE means N_PE. Latched on accepted start.
- stall_i  in  1  SRAM not granted this cycle. No read is issued.
- q_i  in  DATA_W  SRAM read data, valid one cycle after rd_en_o.
- addr_o  out  ADDR_W  SRAM read address.
- rd_en_o  out  1  SRAM read strobe.
- busy_o  out  1  high from the accepted start until done_o inclusive.
- done_o  out  1  one-cycle pulse at load completion.
- weights_valid_o  out  1  all requested weights latched. Cleared by the next accepted start.
- preload_ens_o  out  N_PE  one-hot strobe; bit k high in the cycle weight k is captured.
- preload_weights_o  out  N_PE*DATA_W  flat bus; slice k = [k*DATA_W +: DATA_W].

Behaviour:
- Reset values: every output 0, all weight registers 0, FSM in IDLE. Reset mid-load aborts immediately; no done_o is issued.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start_i. Latches base, n = sat(num_i), rd_idx = 0, clears weights_valid_o.
  - On the same edge, weight registers with index >= n are zeroed. Registers below n keep old values until overwritten.
  - FETCH, stall_i = 0: rd_en_o = 1, addr_o = base + rd_idx (mod 2^ADDR_W), rd_idx++.
  - FETCH, stall_i = 1: rd_en_o = 0, rd_idx holds, addr_o holds its value.
  - FETCH -> DRAIN on the edge that issues read n-1.
  - DRAIN -> DONE after 1 cycle. DONE -> IDLE after 1 cycle.
- Capture pipeline:
  - rd_en_o and rd_idx are registered into cap_v and cap_idx.
  - When cap_v = 1: preload_ens_o[cap_idx] = 1 (combinational from the registers) and weight[cap_idx] <= q_i on that edge.
  - cap_v = 0 implies preload_ens_o = 0.
- Latency, no stall, start sampled at the end of cycle 0:
  - reads in cycles 1..n;
  - preload_ens_o[k] in cycle k+2;
  - weight k visible on preload_weights_o from cycle k+3;
  - done_o and weights_valid_o rise in cycle n+2;
  - busy_o high in cycles 1..n+2.
- Each stall cycle adds exactly one cycle of latency. Stall in DRAIN, DONE or IDLE has no effect.
- start_i while busy_o is ignored; no queueing.
- rd_en_o is never high outside FETCH.
- Exactly n preload_ens_o pulses per load, each index 0..n-1 once, in ascending order.
- Address wrap past 2^ADDR_W-1 is silent modulo arithmetic.
- rst takes precedence over start_i in the same cycle.

Decomposition:
- Package weight_preloader_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - default N_PE/DATA_W/ADDR_W constants;
  - a count-saturation function.
- One sub-module: preload_addr_gen. It owns base/rd_idx/n, stall handling, rd_en_o/addr_o generation and the last-read flag. The capture register bank and one-hot decode stay in the top.

Test Plan:
- Full load: N_PE=9, base=0, num=0, memory[i]=i+1, no stall -> addr_o 0..8 in cycles 1..9; ens one-hot bit k in cycle k+2; done_o in cycle 11; weights = 1..9.
- Partial + zeroing: preload all weights 0xFF, then start base=20, num=4 -> ens bits 0..3 only; weights[0..3] = mem[20..23]; weights[4..8] = 0; done_o in cycle 6.
- Stall: full load with stall_i high in cycles 3 and 4 -> addr_o holds 2 during stall with rd_en_o=0; done_o in cycle 13; weight values are identical to the no-stall run.
- Wrap: ADDR_W=6, base=62, num=4 -> addresses 62, 63, 0, 1; weights = mem[62], mem[63], mem[0], mem[1].
- Busy start + oversize: num=15 -> n=9. start_i pulsed in cycle 5 is ignored, so exactly 9 ens pulses and one done_o.
- Reset mid-load: rst in cycle 5 of a full load -> next cycle all outputs and weights 0, no done_o. A new start then completes normally.

Source files
------------

// File: rtl/weight_preloader_pkg.sv
// Shared types, default sizes and helpers for the parametrised weight preloader.
package weight_preloader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N_PE   = 9;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;

  // A request of zero, or more weights than there are PEs, loads the whole array.
  function automatic int unsigned sat_count(input int unsigned num, input int unsigned n_pe);
    if ((num == 0) || (num > n_pe)) begin
      return n_pe;
    end
    return num;
  endfunction

endpackage

// File: rtl/weight_preloader_param_addr_gen.sv
// SRAM read-address generator: holds base/count/read index, issues one read
// per granted FETCH cycle and flags the final read of a load.
module preload_addr_gen
  import weight_preloader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_num,
  input  logic              i_fetch,
  input  logic              i_stall,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [CNT_W-1:0]  o_rd_idx,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_rd_idx;
  logic              w_issue;

  // A read goes out only while fetching and the SRAM port is granted.
  assign w_issue  = i_fetch && !i_stall;
  assign o_rd_en  = w_issue;
  // Address wraps silently modulo 2^ADDR_W; it naturally holds during a stall
  // because the index does not advance.
  assign o_addr   = r_base + ADDR_W'(r_rd_idx);
  assign o_rd_idx = r_rd_idx;
  assign o_last   = w_issue && (r_rd_idx == (r_n - CNT_W'(1)));

  // Latch the load descriptor on an accepted start, advance per issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= '0;
      r_n      <= '0;
      r_rd_idx <= '0;
    end else if (i_start) begin
      r_base   <= i_base;
      r_n      <= i_num;
      r_rd_idx <= '0;
    end else if (w_issue) begin
      r_rd_idx <= r_rd_idx + CNT_W'(1);
    end
  end

endmodule

// File: rtl/weight_preloader_param.sv
// Systolic-array weight preloader: fetches up to N_PE weights from a
// synchronous-read SRAM and strobes each into its PE holding register.
module weight_preloader_param
  import weight_preloader_pkg::*;
#(
  parameter int N_PE   = DEF_N_PE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = $clog2(N_PE + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [CNT_W-1:0]         num_i,
  input  logic                     stall_i,
  input  logic [DATA_W-1:0]        q_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     rd_en_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     weights_valid_o,
  output logic [N_PE-1:0]          preload_ens_o,
  output logic [N_PE*DATA_W-1:0]   preload_weights_o
);

  state_e            r_state;
  state_e            w_state_next;
  logic              w_fetch;
  logic              w_start_acc;
  logic              w_last_rd;
  logic              w_rd_en;
  logic [CNT_W-1:0]  w_rd_idx;
  logic [CNT_W-1:0]  w_n_start;
  logic              r_cap_v;
  logic [CNT_W-1:0]  r_cap_idx;
  logic              r_weights_valid;
  logic [DATA_W-1:0] r_weight [N_PE];

  assign w_start_acc = (r_state == IDLE) && start_i;
  assign w_n_start   = CNT_W'(sat_count(32'(num_i), N_PE));

  preload_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start_acc),
    .i_base   (base_addr_i),
    .i_num    (w_n_start),
    .i_fetch  (w_fetch),
    .i_stall  (stall_i),
    .o_rd_en  (w_rd_en),
    .o_addr   (addr_o),
    .o_rd_idx (w_rd_idx),
    .o_last   (w_last_rd)
  );

  assign rd_en_o = w_rd_en;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; starts arriving outside IDLE are dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i)   w_state_next = FETCH;
      FETCH:   if (w_last_rd) w_state_next = DRAIN;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    w_fetch = (r_state == FETCH);
    busy_o  = (r_state != IDLE);
    done_o  = (r_state == DONE);
  end

  // Capture pipeline: read data returns one cycle after the strobe, so the
  // strobe and its index are delayed by one cycle to steer the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_v   <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_cap_v   <= w_rd_en;
      r_cap_idx <= w_rd_idx;
    end
  end

  // Valid flag rises as the final capture lands (DRAIN) and drops on a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_weights_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_weights_valid <= 1'b0;
    end else if (r_state == DRAIN) begin
      r_weights_valid <= 1'b1;
    end
  end

  assign weights_valid_o = r_weights_valid;

  generate
    for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe
      // One-hot enable for this PE straight from the capture registers.
      assign preload_ens_o[gi] = r_cap_v && (r_cap_idx == CNT_W'(gi));

      // Holding register: cleared when outside the new load's range,
      // otherwise overwritten when its capture slot comes around.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_weight[gi] <= '0;
        end else if (w_start_acc && (CNT_W'(gi) >= w_n_start)) begin
          r_weight[gi] <= '0;
        end else if (r_cap_v && (r_cap_idx == CNT_W'(gi))) begin
          r_weight[gi] <= q_i;
        end
      end

      assign preload_weights_o[gi*DATA_W +: DATA_W] = r_weight[gi];
    end
  endgenerate

endmodule
